lsu: RTL
========

# lsu

Load/store unit sitting directly downstream of the execute stage. It takes the ALU-computed effective address and the pass-through rs2 value, then runs one data-bus transaction per request over a valid/ready command/response bus. It returns aligned, sign- or zero-extended load data, or a store completion, to writeback. Misaligned and illegal accesses are rejected without a bus cycle, and a watchdog bounds every bus transaction.

## Interface
Parameters:
- TIMEOUT, 255: cycles allowed in CMD+RSP before abort (1..255, 8-bit counter).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- lsu_i_valid  in  1  memory request from core; held until lsu_o_done.
- lsu_i_we  in  1  1 = store, 0 = load.
- lsu_i_funct3  in  3  access type (RV32I load/store funct3).
- lsu_i_addr  in  32  effective address (execute-stage result).
- lsu_i_wdata  in  32  store data (rs2).
- lsu_o_done  out  1  one-cycle completion pulse.
- lsu_o_rdata  out  32  extended load data, valid with done; 0 for stores and errors.
- lsu_o_err  out  2  valid with done: 00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout.
- lsu_o_busy  out  1  state != IDLE.
- lsu_o_cmd_valid  out  1  bus command valid.
- lsu_i_cmd_ready  in  1  bus command accepted.
- lsu_o_cmd_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- lsu_o_cmd_write  out  1  store command.
- lsu_o_cmd_wdata  out  32  lane-replicated store data.
- lsu_o_cmd_wmask  out  4  byte enables.
- lsu_i_rsp_valid  in  1  bus response valid (response always accepted).
- lsu_i_rsp_rdata  in  32  response word.
- lsu_i_rsp_err  in  1  bus error flag.

## Operation
- FSM states: IDLE, CMD, RSP. Reset: state IDLE; all outputs 0; counter 0.
- IDLE with lsu_i_valid: decode funct3. Legal loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores 000 SB, 001 SH, 010 SW.
- Illegal funct3, halfword with addr[0]=1, or word with addr[1:0]!=0: stay IDLE. Next cycle pulse done with err=01 and rdata=0. No bus activity.
- Legal request: capture addr[1:0], funct3 and we. Register cmd_addr, cmd_write, cmd_wdata and cmd_wmask; go to CMD. Counter clears.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Store mask: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111. Loads have wmask=0000.
- CMD: cmd_valid=1. If cmd_ready, go to RSP and cmd_valid drops next cycle. Command fields are stable while valid.
- RSP: on rsp_valid, go to IDLE and pulse done next cycle.
- Response with rsp_err=1: err=10, rdata=0.
- Load response: select byte rsp_rdata[8*addr[1:0]+:8] or halfword rsp_rdata[16*addr[1]+:16]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Store response: rdata=0, err=00.
- Watchdog: the counter increments each cycle in CMD or RSP. When it equals TIMEOUT-1 and no handshake occurs that cycle, go to IDLE, drop cmd_valid and pulse done with err=11.
- A rsp_valid arriving in IDLE or CMD is ignored. A late response to a timed-out command is a system fault and is not detected.

## Timing
- Outputs done, rdata, err and all cmd_* are registered. busy is decoded from state.
- Best case is done 3 cycles after lsu_i_valid is sampled:
  - T0: request accepted.
  - T1: cmd_valid=1 with cmd_ready=1.
  - T2: rsp_valid=1.
  - T3: done=1.
- Each cycle cmd_ready or rsp_valid is low adds one cycle.
- A reject asserts done at T1.
- done is high exactly one cycle and coincides with state IDLE. A new lsu_i_valid in the done cycle is accepted (back-to-back, no bubble).
- lsu_i_valid is sampled only in IDLE; inputs are don't-care elsewhere.
- If rst is asserted mid-transaction, all outputs clear immediately (cmd_valid drops asynchronously) and no done is produced.

## Test plan
- LW addr 0x100, cmd_ready=1 at T1, rsp 0xDEADBEEF at T2 -> cmd_addr 0x100, wmask 0000; done at T3, rdata 0xDEADBEEF, err 00.
- LB addr 0x103, rsp 0x80FF_0000 -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF. LHU -> 0x000080FF.
- SB addr 0x201, wdata 0x123456AB -> cmd_addr 0x200, wdata 0xABABABAB, wmask 0010, write=1. SH addr 0x202 -> wmask 1100, wdata 0x56AB56AB.
- LW addr 0x102, then funct3 011 -> each gives done at T1, err 01, cmd_valid never asserted.
- cmd_ready held low 3 cycles, then rsp_err=1 -> done 3 cycles later than best case, err 10, rdata 0.
- TIMEOUT=4, cmd_ready never asserted -> cmd_valid T1..T4, done at T5, err 11. Then back-to-back LW in the done cycle -> accepted, completes normally.
- rst low while in RSP -> cmd_valid, done and busy are 0 immediately; after release, a new LW completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: decodes a core memory request, runs one command/response
// bus transaction (or rejects it locally) and returns extended load data.
module lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        lsu_i_valid,
   input  logic        lsu_i_we,
   input  logic [2:0]  lsu_i_funct3,
   input  logic [31:0] lsu_i_addr,
   input  logic [31:0] lsu_i_wdata,
   output logic        lsu_o_done,
   output logic [31:0] lsu_o_rdata,
   output logic [1:0]  lsu_o_err,
   output logic        lsu_o_busy,

   output logic        lsu_o_cmd_valid,
   input  logic        lsu_i_cmd_ready,
   output logic [31:0] lsu_o_cmd_addr,
   output logic        lsu_o_cmd_write,
   output logic [31:0] lsu_o_cmd_wdata,
   output logic [3:0]  lsu_o_cmd_wmask,

   input  logic        lsu_i_rsp_valid,
   input  logic [31:0] lsu_i_rsp_rdata,
   input  logic        lsu_i_rsp_err
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_BUS     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_RSP  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          addr_lo_q, addr_lo_d;
   logic [2:0]          funct3_q, funct3_d;
   logic                we_q, we_d;

   logic                done_q, done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          err_q, err_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic [DATA_W-1:0]   cmd_addr_q, cmd_addr_d;
   logic                cmd_write_q, cmd_write_d;
   logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
   logic [3:0]          cmd_wmask_q, cmd_wmask_d;

   logic                legal_c;
   logic [DATA_W-1:0]   st_wdata_c;
   logic [3:0]          st_wmask_c;
   logic [DATA_W-1:0]   ld_data_c;
   logic [DATA_W-1:0]   rsp_shift_c;
   logic [15:0]         rsp_half_c;
   logic                wd_expire_c;

   // Request legality: funct3 must name a valid access and be naturally aligned
   always_comb begin
      legal_c = 1'b0;
      case (lsu_i_funct3)
         3'b000:  legal_c = 1'b1;
         3'b001:  legal_c = ~lsu_i_addr[0];
         3'b010:  legal_c = (lsu_i_addr[1:0] == 2'b00);
         3'b100:  legal_c = ~lsu_i_we;
         3'b101:  legal_c = ~lsu_i_we & ~lsu_i_addr[0];
         default: legal_c = 1'b0;
      endcase
   end

   // Store lane replication and byte-enable generation (loads carry no enables)
   always_comb begin
      st_wdata_c = lsu_i_wdata;
      st_wmask_c = 4'b1111;
      case (lsu_i_funct3[1:0])
         2'b00: begin
            st_wdata_c = {4{lsu_i_wdata[7:0]}};
            st_wmask_c = 4'b0001 << lsu_i_addr[1:0];
         end
         2'b01: begin
            st_wdata_c = {2{lsu_i_wdata[15:0]}};
            st_wmask_c = 4'b0011 << lsu_i_addr[1:0];
         end
         default: begin
            st_wdata_c = lsu_i_wdata;
            st_wmask_c = 4'b1111;
         end
      endcase
      if (!lsu_i_we) begin
         st_wmask_c = 4'b0000;
      end
   end

   // Load lane selection and sign/zero extension from the response word
   always_comb begin
      rsp_shift_c = lsu_i_rsp_rdata >> {addr_lo_q, 3'b000};
      rsp_half_c  = addr_lo_q[1] ? lsu_i_rsp_rdata[31:16] : lsu_i_rsp_rdata[15:0];
      ld_data_c   = lsu_i_rsp_rdata;
      case (funct3_q)
         3'b000:  ld_data_c = {{24{rsp_shift_c[7]}}, rsp_shift_c[7:0]};
         3'b001:  ld_data_c = {{16{rsp_half_c[15]}}, rsp_half_c};
         3'b100:  ld_data_c = {24'h000000, rsp_shift_c[7:0]};
         3'b101:  ld_data_c = {16'h0000, rsp_half_c};
         default: ld_data_c = lsu_i_rsp_rdata;
      endcase
   end

   assign wd_expire_c = (cnt_q == CNT_LAST);

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_lo_d   = addr_lo_q;
      funct3_d    = funct3_q;
      we_d        = we_q;
      done_d      = 1'b0;
      rdata_d     = '0;
      err_d       = ERR_OK;
      cmd_valid_d = 1'b0;
      cmd_addr_d  = cmd_addr_q;
      cmd_write_d = cmd_write_q;
      cmd_wdata_d = cmd_wdata_q;
      cmd_wmask_d = cmd_wmask_q;

      unique case (state_q)
         S_IDLE: begin
            if (lsu_i_valid) begin
               if (!legal_c) begin
                  done_d = 1'b1;
                  err_d  = ERR_ALIGN;
               end else begin
                  state_d     = S_CMD;
                  cnt_d       = '0;
                  addr_lo_d   = lsu_i_addr[1:0];
                  funct3_d    = lsu_i_funct3;
                  we_d        = lsu_i_we;
                  cmd_valid_d = 1'b1;
                  cmd_addr_d  = {lsu_i_addr[31:2], 2'b00};
                  cmd_write_d = lsu_i_we;
                  cmd_wdata_d = st_wdata_c;
                  cmd_wmask_d = st_wmask_c;
               end
            end
         end
         S_CMD: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (lsu_i_cmd_ready) begin
               state_d = S_RSP;
            end else if (wd_expire_c) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               err_d   = ERR_TIMEOUT;
            end else begin
               cmd_valid_d = 1'b1;
            end
         end
         S_RSP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (lsu_i_rsp_valid) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               if (lsu_i_rsp_err) begin
                  err_d = ERR_BUS;
               end else if (!we_q) begin
                  rdata_d = ld_data_c;
               end
            end else if (wd_expire_c) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               err_d   = ERR_TIMEOUT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_lo_q   <= '0;
         funct3_q    <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         rdata_q     <= '0;
         err_q       <= ERR_OK;
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_write_q <= 1'b0;
         cmd_wdata_q <= '0;
         cmd_wmask_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_lo_q   <= addr_lo_d;
         funct3_q    <= funct3_d;
         we_q        <= we_d;
         done_q      <= done_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_write_q <= cmd_write_d;
         cmd_wdata_q <= cmd_wdata_d;
         cmd_wmask_q <= cmd_wmask_d;
      end
   end

   assign lsu_o_done      = done_q;
   assign lsu_o_rdata     = rdata_q;
   assign lsu_o_err       = err_q;
   assign lsu_o_busy      = (state_q != S_IDLE);
   assign lsu_o_cmd_valid = cmd_valid_q;
   assign lsu_o_cmd_addr  = cmd_addr_q;
   assign lsu_o_cmd_write = cmd_write_q;
   assign lsu_o_cmd_wdata = cmd_wdata_q;
   assign lsu_o_cmd_wmask = cmd_wmask_q;

endmodule
